// File: rtl/cmul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cmul_pkg
// Purpose  : Shared constants and types for the complex multiply scheduler:
//            complex word/component widths, operand mode encodings, FSM
//            state type and an index-width helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package cmul_pkg;

    // A complex word is {real[63:32], imag[31:0]}, each an IEEE-754 single.
    localparam int c_word_w = 64;
    localparam int c_comp_w = 32;
    localparam int c_mode_w = 2;

    typedef enum logic [1:0] {
        MODE_PLAIN   = 2'b00,
        MODE_CONJ_A  = 2'b01,
        MODE_CONJ_B  = 2'b10,
        MODE_CONJ_AB = 2'b11
    } cmul_mode_t;

    typedef enum logic [1:0] {
        ST_INIT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10
    } cmul_state_t;

    // Width of an index into n items; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin arbiter. Grants the lowest index at or
//            above the pointer whose request is set, wrapping past NUM_REQ-1.
// Ports    : req     - per-requester request vector
//            pointer - index with highest priority this cycle
//            grant   - one-hot grant (all zero when no request)
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import cmul_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   pointer,
    output logic [NUM_REQ-1:0] grant
);

    int               w_sum;
    logic [PTR_W-1:0] w_idx;
    logic             w_found;

    // Walk the requesters starting at the pointer; the first hit wins.
    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        w_sum   = 0;
        w_idx   = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            w_sum = int'(pointer) + off;
            if (w_sum >= NUM_REQ) begin
                w_sum = w_sum - NUM_REQ;
            end
            w_idx = PTR_W'(w_sum);
            if (!w_found && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/complex_multiply_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : complex_multiply_scheduler
// Purpose  : Shares one pipelined complex multiplier between NUM_REQ
//            requesters. Round-robin issue of at most one operation per
//            cycle, a tag pipe matching the multiplier latency steers each
//            result back to its requester, and a flush/drain mode stops
//            issue until everything in flight has returned.
// Config   : define CMUL_CONJ_MODE_EN to add per-requester operand mode
//            (req_mode) forwarded alongside the operands on mul_mode.
// Ports    : clk, rst_n            - clock, synchronous active-low reset
//            req_valid/req_ready   - per-requester handshake (ready one-hot)
//            req_a, req_b          - packed operands, slot i at [64*i +: 64]
//            mul_a, mul_b, mul_ce  - registered operands / enable to multiplier
//            mul_result            - multiplier output
//            rsp_valid, rsp_data   - one-hot result strobe and result word
//            flush, flush_done     - drain request / one-cycle completion pulse
//            busy                  - an operation is in flight
// Revision : 1.0 - initial release
// ============================================================================
module complex_multiply_scheduler
    import cmul_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int MUL_LATENCY = 12
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*c_word_w-1:0]  req_a,
    input  logic [NUM_REQ*c_word_w-1:0]  req_b,
`ifdef CMUL_CONJ_MODE_EN
    input  logic [NUM_REQ*c_mode_w-1:0]  req_mode,
    output logic [c_mode_w-1:0]          mul_mode,
`endif
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [c_word_w-1:0]          mul_a,
    output logic [c_word_w-1:0]          mul_b,
    output logic                         mul_ce,
    input  logic [c_word_w-1:0]          mul_result,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [c_word_w-1:0]          rsp_data,
    input  logic                         flush,
    output logic                         flush_done,
    output logic                         busy
);

    localparam int c_id_w  = idx_w(NUM_REQ);
    localparam int c_cnt_w = idx_w(MUL_LATENCY) + 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    cmul_state_t             r_state;
    logic [c_cnt_w-1:0]      r_init_cnt;
    logic                    r_flush_done;
    logic [c_id_w-1:0]       r_ptr;
    logic [c_word_w-1:0]     r_mul_a;
    logic [c_word_w-1:0]     r_mul_b;
    logic                    r_issue_valid;
    logic [c_id_w-1:0]       r_issue_id;
    logic [MUL_LATENCY-1:0]  r_tag_valid;
    logic [c_id_w-1:0]       r_tag_id [MUL_LATENCY];
`ifdef CMUL_CONJ_MODE_EN
    logic [c_mode_w-1:0]     r_mul_mode;
    logic [c_mode_w-1:0]     w_sel_mode;
`endif

    logic [NUM_REQ-1:0]      w_grant;
    logic [NUM_REQ-1:0]      w_ready;
    logic                    w_fire;
    logic [c_id_w-1:0]       w_fire_id;
    logic [c_id_w-1:0]       w_next_ptr;
    logic [c_word_w-1:0]     w_sel_a;
    logic [c_word_w-1:0]     w_sel_b;
    logic                    w_busy;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (c_id_w)
    ) u_rr_arbiter (
        .req     (req_valid),
        .pointer (r_ptr),
        .grant   (w_grant)
    );

    // Grants only in RUN, and a flush request blocks issue in the very
    // cycle it is raised so nothing new enters behind the drain.
    assign w_ready = (r_state == ST_RUN && !flush) ? w_grant : '0;
    assign w_fire  = |(req_valid & w_ready);

    // One-hot grant to index plus operand mux, built from constant slices.
    always_comb begin
        w_fire_id = '0;
        w_sel_a   = '0;
        w_sel_b   = '0;
`ifdef CMUL_CONJ_MODE_EN
        w_sel_mode = MODE_PLAIN;
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_ready[i]) begin
                w_fire_id = c_id_w'(i);
                w_sel_a   = req_a[i*c_word_w +: c_word_w];
                w_sel_b   = req_b[i*c_word_w +: c_word_w];
`ifdef CMUL_CONJ_MODE_EN
                w_sel_mode = req_mode[i*c_mode_w +: c_mode_w];
`endif
            end
        end
    end

    assign w_next_ptr = (w_fire_id == c_id_w'(NUM_REQ - 1)) ? '0 : w_fire_id + 1'b1;

    // ------------------------------------------------------------------
    // Issue register and tag pipe. The issue stage plus MUL_LATENCY tag
    // stages line up the tag tail with the multiplier output, giving
    // MUL_LATENCY+1 cycles from handshake to response.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr         <= '0;
            r_mul_a       <= '0;
            r_mul_b       <= '0;
            r_issue_valid <= 1'b0;
            r_issue_id    <= '0;
            r_tag_valid   <= '0;
            for (int i = 0; i < MUL_LATENCY; i++) begin
                r_tag_id[i] <= '0;
            end
`ifdef CMUL_CONJ_MODE_EN
            r_mul_mode    <= MODE_PLAIN;
`endif
        end else begin
            r_issue_valid <= w_fire;
            if (w_fire) begin
                r_ptr      <= w_next_ptr;
                r_mul_a    <= w_sel_a;
                r_mul_b    <= w_sel_b;
                r_issue_id <= w_fire_id;
`ifdef CMUL_CONJ_MODE_EN
                r_mul_mode <= w_sel_mode;
`endif
            end
            r_tag_valid[0] <= r_issue_valid;
            r_tag_id[0]    <= r_issue_id;
            for (int i = 1; i < MUL_LATENCY; i++) begin
                r_tag_valid[i] <= r_tag_valid[i-1];
                r_tag_id[i]    <= r_tag_id[i-1];
            end
        end
    end

    assign w_busy = r_issue_valid | (|r_tag_valid);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_INIT;
            r_init_cnt   <= '0;
            r_flush_done <= 1'b0;
        end else begin
            r_flush_done <= 1'b0;
            case (r_state)
                // Let the free-running multiplier flush out whatever it held
                // before reset; zero operands are fed the whole time.
                ST_INIT: begin
                    if (r_init_cnt == c_cnt_w'(MUL_LATENCY - 1)) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_init_cnt <= r_init_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!w_busy) begin
                        r_state      <= ST_RUN;
                        r_flush_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Results cannot be back-pressured, so the response is steered
    // straight from the tag tail and the multiplier output.
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = r_tag_valid[MUL_LATENCY-1] &&
                           (r_tag_id[MUL_LATENCY-1] == c_id_w'(i));
        end
    end

    assign rsp_data   = mul_result;
    assign req_ready  = w_ready;
    assign mul_a      = r_mul_a;
    assign mul_b      = r_mul_b;
    assign mul_ce     = 1'b1;
    assign flush_done = r_flush_done;
    assign busy       = w_busy;
`ifdef CMUL_CONJ_MODE_EN
    assign mul_mode   = r_mul_mode;
`endif

endmodule
`default_nettype wire

// File: tb/tb_complex_multiply_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_complex_multiply_scheduler
// Purpose  : Directed, table-driven bench for complex_multiply_scheduler with
//            a behavioural single-precision complex multiplier of latency 12.
// Revision : 1.0 - initial release
// ============================================================================
module tb_complex_multiply_scheduler;

    localparam int N = 4;
    localparam int L = 12;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N*64-1:0]  req_a;
    logic [N*64-1:0]  req_b;
    logic [N-1:0]     req_ready;
    logic [63:0]      mul_a;
    logic [63:0]      mul_b;
    logic             mul_ce;
    logic [63:0]      mul_result;
    logic [N-1:0]     rsp_valid;
    logic [63:0]      rsp_data;
    logic             flush;
    logic             flush_done;
    logic             busy;
`ifdef CMUL_CONJ_MODE_EN
    logic [N*2-1:0]   req_mode;
    logic [1:0]       mul_mode;
`endif

    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;

    complex_multiply_scheduler #(
        .NUM_REQ     (N),
        .MUL_LATENCY (L)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
`ifdef CMUL_CONJ_MODE_EN
        .req_mode   (req_mode),
        .mul_mode   (mul_mode),
`endif
        .req_ready  (req_ready),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_ce     (mul_ce),
        .mul_result (mul_result),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .flush      (flush),
        .flush_done (flush_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural multiplier ----------------
    function automatic real sp2r(input logic [31:0] x);
        logic [10:0] e;
        if (x[30:0] == 31'h0) return 0.0;
        e = {3'b000, x[30:23]} + 11'd896;
        return $bitstoreal({x[31], e, x[22:0], 29'h0});
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [63:0] cmul(input logic [63:0] a, input logic [63:0] b);
        real ar, ai, br, bi;
        ar = sp2r(a[63:32]); ai = sp2r(a[31:0]);
        br = sp2r(b[63:32]); bi = sp2r(b[31:0]);
        return {r2sp(ar*br - ai*bi), r2sp(ar*bi + ai*br)};
    endfunction

    logic [63:0] mpipe [L];
    always @(posedge clk) begin
        if (mul_ce) begin
            mpipe[0] <= cmul(mul_a, mul_b);
            for (int i = 1; i < L; i++) mpipe[i] <= mpipe[i-1];
        end
    end
    assign mul_result = mpipe[L-1];

    // ---------------- helpers ----------------
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (busy && k < 40) begin
            nxt();
            @(negedge clk);
            k++;
        end
        chk(name, {63'h0, busy}, 64'h0);
        nxt();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    typedef struct {
        int          slot;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp_d;
    } vec_t;

    vec_t        vecs [5];
    logic [63:0] exp_rr [N];
    logic [N-1:0] got_v [8];
    logic [63:0] got_d [8];
    int          got_c [8];
    int          n_got, h, h0, k, last_rsp, fd_cyc, fd_cnt, nrsp, ngrant;
    logic        bad, leak, fd_seen;
    logic [N-1:0] fd_ready;

    initial begin
        vecs[0] = '{0, 64'h3F800000_40000000, 64'h40400000_40800000, 64'hC0A00000_41200000};
        vecs[1] = '{1, 64'h40000000_00000000, 64'h3F000000_00000000, 64'h3F800000_00000000};
        vecs[2] = '{2, 64'h00000000_3F800000, 64'h00000000_3F800000, 64'hBF800000_00000000};
        vecs[3] = '{3, 64'h3F800000_BF800000, 64'h3F800000_3F800000, 64'h40000000_00000000};
        vecs[4] = '{2, 64'h40400000_00000000, 64'hC0000000_40A00000, 64'hC0C00000_41700000};
        exp_rr[0] = 64'h40000000_00000000;
        exp_rr[1] = 64'h40800000_00000000;
        exp_rr[2] = 64'h40C00000_00000000;
        exp_rr[3] = 64'h41000000_00000000;

        // Slot i operands: (i+1) * 2
        req_a = {64'h40800000_00000000, 64'h40400000_00000000,
                 64'h40000000_00000000, 64'h3F800000_00000000};
        req_b = {4{64'h40000000_00000000}};
`ifdef CMUL_CONJ_MODE_EN
        req_mode = '0;
`endif
        rst_n     = 1'b0;
        req_valid = 4'hF;
        flush     = 1'b0;

        // ---- reset state ----
        repeat (3) nxt();
        @(negedge clk);
        chk("reset busy", {63'h0, busy}, 64'h0);
        chk("reset mul_a", mul_a, 64'h0);
        chk("reset mul_b", mul_b, 64'h0);
        chk("reset ready", {60'h0, req_ready}, 64'h0);
        chk("reset rsp_valid/flush_done", {59'h0, rsp_valid, flush_done}, 64'h0);
        nxt();
        rst_n = 1'b1;

        // ---- INIT: 12 cycles without grants or responses ----
        bad = 1'b0;
        for (int c = 1; c <= L; c++) begin
            @(negedge clk);
            if (req_ready != 0 || rsp_valid != 0 || mul_ce !== 1'b1) bad = 1'b1;
            nxt();
        end
        chk("init quiet", {63'h0, bad}, 64'h0);

        // ---- round robin with all four held: grants 0,1,2,3,0 ----
        h0 = 0;
        for (int g = 0; g < 5; g++) begin
            @(negedge clk);
            if (g == 0) h0 = cyc;
            chk($sformatf("rr grant %0d", g), {60'h0, req_ready}, 64'(4'b0001 << (g % 4)));
            nxt();
        end
        req_valid = '0;
        @(negedge clk);
        chk("busy in flight", {63'h0, busy}, 64'h1);
        n_got = 0;
        for (int c = 0; c < 30; c++) begin
            if (|rsp_valid && n_got < 8) begin
                got_v[n_got] = rsp_valid; got_d[n_got] = rsp_data; got_c[n_got] = cyc;
                n_got++;
            end
            nxt();
            @(negedge clk);
        end
        chk("rr response count", 64'(n_got), 64'd5);
        for (int j = 0; j < 5 && j < n_got; j++) begin
            chk($sformatf("rr rsp%0d id", j), {60'h0, got_v[j]}, 64'(4'b0001 << (j % 4)));
            chk($sformatf("rr rsp%0d data", j), got_d[j], exp_rr[j % 4]);
            chk($sformatf("rr rsp%0d cycle", j), 64'(got_c[j] - h0), 64'(L + 1 + j));
        end
        chk("idle after rr", {63'h0, busy}, 64'h0);
        nxt();

        // ---- table of single operations ----
        for (int v = 0; v < 5; v++) begin
            req_a[vecs[v].slot*64 +: 64] = vecs[v].a;
            req_b[vecs[v].slot*64 +: 64] = vecs[v].b;
            req_valid = 4'b0001 << vecs[v].slot;
            k = 0;
            @(negedge clk);
            while (req_ready == 0 && k < 20) begin nxt(); @(negedge clk); k++; end
            chk($sformatf("vec%0d grant", v), {60'h0, req_ready}, 64'(4'b0001 << vecs[v].slot));
            h = cyc;
            nxt();
            req_valid = '0;
            @(negedge clk);
            chk($sformatf("vec%0d mul_a", v), mul_a, vecs[v].a);
            chk($sformatf("vec%0d mul_b", v), mul_b, vecs[v].b);
            k = 0;
            while (rsp_valid == 0 && k < 30) begin nxt(); @(negedge clk); k++; end
            chk($sformatf("vec%0d rsp_valid", v), {60'h0, rsp_valid}, 64'(4'b0001 << vecs[v].slot));
            chk($sformatf("vec%0d rsp_data", v), rsp_data, vecs[v].exp_d);
            chk($sformatf("vec%0d latency", v), 64'(cyc - h), 64'(L + 1));
            chk($sformatf("vec%0d mul_a hold", v), mul_a, vecs[v].a);
            nxt();
            wait_idle($sformatf("vec%0d drain", v));
        end

        // ---- flush with five operations in flight ----
        req_valid = 4'hF;
        ngrant = 0;
        for (int g = 0; g < 5; g++) begin
            @(negedge clk);
            if (req_ready != 0) ngrant++;
            nxt();
        end
        chk("flush setup grants", 64'(ngrant), 64'd5);
        flush = 1'b1;
        @(negedge clk);
        chk("ready with flush", {60'h0, req_ready}, 64'h0);
        nxt();
        flush = 1'b0;
        fd_seen = 1'b0; leak = 1'b0; nrsp = 0; last_rsp = 0; fd_cyc = 0; fd_ready = '0;
        for (int c = 0; c < 40 && !fd_seen; c++) begin
            @(negedge clk);
            if (|rsp_valid) begin nrsp++; last_rsp = cyc; end
            if (flush_done) begin
                fd_seen = 1'b1; fd_cyc = cyc; fd_ready = req_ready;
            end else if (req_ready != 0) begin
                leak = 1'b1;
            end
            nxt();
        end
        req_valid = '0;
        chk("flush_done seen", {63'h0, fd_seen}, 64'h1);
        chk("no grant in drain", {63'h0, leak}, 64'h0);
        chk("drain responses", 64'(nrsp), 64'd5);
        chk("flush_done timing", 64'(fd_cyc - last_rsp), 64'd2);
        chk("grant resumes", {63'h0, (fd_ready != 0)}, 64'h1);
        fd_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (flush_done) fd_cnt++;
            nxt();
        end
        chk("flush_done single pulse", 64'(fd_cnt), 64'd0);
        wait_idle("flush tail drain");

        // ---- flush with empty pipe ----
        req_valid = 4'b0010;
        flush = 1'b1;
        @(negedge clk);
        chk("empty flush ready F", {60'h0, req_ready}, 64'h0);
        nxt();
        flush = 1'b0;
        @(negedge clk);
        chk("empty flush F+1", {59'h0, req_ready, flush_done}, 64'h0);
        nxt();
        @(negedge clk);
        chk("empty flush F+2 done", {63'h0, flush_done}, 64'h1);
        chk("empty flush F+2 ready", {60'h0, req_ready}, 64'h2);
        nxt();
        req_valid = '0;
        wait_idle("empty flush drain");

        // ---- reset four cycles after issue ----
        req_valid = 4'b0100;
        @(negedge clk);
        chk("kill op grant", {60'h0, req_ready}, 64'h4);
        nxt();
        repeat (3) nxt();
        rst_n = 1'b0;
        nxt();
        rst_n = 1'b1;
        bad = 1'b0; leak = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (rsp_valid != 0) bad = 1'b1;
            if (c <= L && req_ready != 0) leak = 1'b1;
            if (c == L + 1) chk("replay first grant", {60'h0, req_ready}, 64'h4);
            nxt();
            if (c == L + 1) req_valid = '0;
        end
        chk("killed op silent", {63'h0, bad}, 64'h0);
        chk("init replayed", {63'h0, leak}, 64'h0);
        wait_idle("post reset drain");

`ifdef CMUL_CONJ_MODE_EN
        // ---- operand mode travels with operands ----
        req_a[63:0] = vecs[0].a;
        req_b[63:0] = vecs[0].b;
        req_mode[1:0] = 2'b11;
        req_valid = 4'b0001;
        @(negedge clk);
        chk("mode grant", {60'h0, req_ready}, 64'h1);
        nxt();
        req_valid = '0;
        @(negedge clk);
        chk("mode mul_mode", {62'h0, mul_mode}, 64'h3);
        chk("mode mul_a", mul_a, vecs[0].a);
        nxt();
        wait_idle("mode drain");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
